mul_share_arbiter: RTL and testbench

//  Round-robin scheduler that shares one shift_and_add_multiplier among NUM_REQ requesters.

---
 rtl/mul_share_arbiter_if.sv | 29 ++
 rtl/mul_share_arbiter.sv | 159 +++++++++++++++
 tb/tb_mul_share_arbiter.sv | 252 +++++++++++++++++++++++++
 3 files changed

// File: rtl/mul_share_arbiter_if.sv
// Requester / response bus of mul_share_arbiter.
// master: requesters plus response consumer. slave: the arbiter.
interface mul_share_arbiter_if #(
  parameter int unsigned WIDTH   = 16,
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned ID_W    = 2
) ();

  logic [NUM_REQ-1:0]       req_valid;
  logic [NUM_REQ*WIDTH-1:0] req_a;
  logic [NUM_REQ*WIDTH-1:0] req_b;
  logic [NUM_REQ-1:0]       req_ready;
  logic                     resp_valid;
  logic                     resp_ready;
  logic [ID_W-1:0]          resp_id;
  logic signed [2*WIDTH:0]  resp_product;
  logic                     resp_error;

  modport master (
    output req_valid, req_a, req_b, resp_ready,
    input  req_ready, resp_valid, resp_id, resp_product, resp_error
  );

  modport slave (
    input  req_valid, req_a, req_b, resp_ready,
    output req_ready, resp_valid, resp_id, resp_product, resp_error
  );

endinterface

// File: rtl/mul_share_arbiter.sv
// Round-robin scheduler sharing one shift-and-add multiplier among NUM_REQ requesters.
// One transaction in flight: accept -> issue -> wait for mul_ready -> hold response.
// Optional watchdog abort of a stuck multiplier: define MUL_ARB_TIMEOUT_EN.
module mul_share_arbiter #(
  parameter int unsigned WIDTH       = 16,
  parameter int unsigned NUM_REQ     = 4,
  parameter int unsigned ID_W        = $clog2(NUM_REQ),
  parameter int unsigned MUL_TIMEOUT = 40
) (
  input  logic                    clk,
  input  logic                    reset,
  mul_share_arbiter_if.slave      bus,
  output logic                    mul_valid,
  output logic signed [WIDTH-1:0] mul_a,
  output logic signed [WIDTH-1:0] mul_b,
  output logic                    mul_reset,
  input  logic signed [2*WIDTH:0] mul_product,
  input  logic                    mul_ready
);

  // Reject configurations the round-robin search and watchdog cannot handle.
  if (NUM_REQ < 2 || MUL_TIMEOUT < 1) begin : g_bad_cfg
    $error("mul_share_arbiter: NUM_REQ must be >= 2 and MUL_TIMEOUT >= 1");
  end

  typedef enum logic [1:0] {IDLE, ISSUE, BUSY, RESP} state_t;

  state_t                  state_q;
  logic [ID_W-1:0]         rr_ptr_q;
  logic [ID_W-1:0]         resp_id_q;
  logic                    resp_valid_q;
  logic signed [2*WIDTH:0] resp_product_q;
  logic                    mul_valid_q;
  logic signed [WIDTH-1:0] mul_a_q;
  logic signed [WIDTH-1:0] mul_b_q;

  logic                    grant_found;
  logic [ID_W-1:0]         grant_idx;
  logic [ID_W-1:0]         cand;
  logic signed [WIDTH-1:0] a_arr [NUM_REQ];
  logic signed [WIDTH-1:0] b_arr [NUM_REQ];

`ifdef MUL_ARB_TIMEOUT_EN
  localparam int unsigned WD_W = $clog2(MUL_TIMEOUT + 1);
  logic [WD_W-1:0] wd_cnt_q;
  logic            mul_abort_q;
  logic            resp_error_q;
`endif

  // Unpack the flat operand buses per requester.
  for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
    assign a_arr[g] = bus.req_a[g*WIDTH +: WIDTH];
    assign b_arr[g] = bus.req_b[g*WIDTH +: WIDTH];
  end

  // First valid requester at or after rr_ptr, searching cyclically (lowest offset wins).
  always_comb begin
    grant_found = 1'b0;
    grant_idx   = '0;
    cand        = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      cand = ID_W'((int'(rr_ptr_q) + k) % NUM_REQ);
      if (bus.req_valid[cand]) begin
        grant_found = 1'b1;
        grant_idx   = cand;
      end
    end
  end

  // Accept strobe is combinational and only exists in IDLE outside reset.
  assign bus.req_ready = (!reset && state_q == IDLE && grant_found) ?
                         (NUM_REQ'(1) << grant_idx) : '0;

  assign bus.resp_valid   = resp_valid_q;
  assign bus.resp_id      = resp_id_q;
  assign bus.resp_product = resp_product_q;
  assign mul_valid        = mul_valid_q;
  assign mul_a            = mul_a_q;
  assign mul_b            = mul_b_q;

`ifdef MUL_ARB_TIMEOUT_EN
  assign bus.resp_error = resp_error_q;
  assign mul_reset      = reset || mul_abort_q;
`else
  assign bus.resp_error = 1'b0;
  assign mul_reset      = reset;
`endif

  // Transaction FSM with registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q        <= IDLE;
      rr_ptr_q       <= '0;
      resp_id_q      <= '0;
      resp_valid_q   <= 1'b0;
      resp_product_q <= '0;
      mul_valid_q    <= 1'b0;
      mul_a_q        <= '0;
      mul_b_q        <= '0;
`ifdef MUL_ARB_TIMEOUT_EN
      wd_cnt_q       <= '0;
      mul_abort_q    <= 1'b0;
      resp_error_q   <= 1'b0;
`endif
    end else begin
`ifdef MUL_ARB_TIMEOUT_EN
      mul_abort_q <= 1'b0;
`endif
      case (state_q)
        IDLE: begin
          if (grant_found) begin
            mul_a_q     <= a_arr[grant_idx];
            mul_b_q     <= b_arr[grant_idx];
            resp_id_q   <= grant_idx;
            mul_valid_q <= 1'b1;
            state_q     <= ISSUE;
          end
        end
        ISSUE: begin
          mul_valid_q <= 1'b0;
`ifdef MUL_ARB_TIMEOUT_EN
          wd_cnt_q    <= '0;
`endif
          state_q     <= BUSY;
        end
        BUSY: begin
          if (mul_ready) begin
            resp_product_q <= mul_product;
            resp_valid_q   <= 1'b1;
`ifdef MUL_ARB_TIMEOUT_EN
            resp_error_q   <= 1'b0;
`endif
            state_q        <= RESP;
          end
`ifdef MUL_ARB_TIMEOUT_EN
          else if (wd_cnt_q == WD_W'(MUL_TIMEOUT - 1)) begin
            mul_abort_q    <= 1'b1;
            resp_product_q <= '0;
            resp_error_q   <= 1'b1;
            resp_valid_q   <= 1'b1;
            state_q        <= RESP;
          end else begin
            wd_cnt_q <= wd_cnt_q + WD_W'(1);
          end
`endif
        end
        RESP: begin
          if (bus.resp_ready) begin
            resp_valid_q <= 1'b0;
            rr_ptr_q     <= (resp_id_q == ID_W'(NUM_REQ - 1)) ? '0 : resp_id_q + ID_W'(1);
            state_q      <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mul_share_arbiter.sv
// Directed bench for mul_share_arbiter with a cycle-accurate multiplier model.
module tb_mul_share_arbiter;

  localparam int W = 16;
  localparam int N = 4;

  logic                clk = 1'b0;
  logic                reset;
  logic                mul_valid, mul_reset, mul_ready;
  logic signed [W-1:0] mul_a, mul_b;
  logic signed [2*W:0] mul_product;

  mul_share_arbiter_if #(.WIDTH(W), .NUM_REQ(N), .ID_W(2)) bus ();

  mul_share_arbiter #(.WIDTH(W), .NUM_REQ(N), .ID_W(2), .MUL_TIMEOUT(40)) dut (
    .clk        (clk),
    .reset      (reset),
    .bus        (bus),
    .mul_valid  (mul_valid),
    .mul_a      (mul_a),
    .mul_b      (mul_b),
    .mul_reset  (mul_reset),
    .mul_product(mul_product),
    .mul_ready  (mul_ready)
  );

  always #5 clk = ~clk;

  // Multiplier model: ready pulses W+1 cycles after the input_valid cycle.
  logic       m_busy;
  logic [4:0] m_cnt;
  logic       stall = 1'b0;
  logic       spur  = 1'b0;

  always @(posedge clk) begin
    if (mul_reset) begin
      m_busy      <= 1'b0;
      m_cnt       <= '0;
      mul_product <= '0;
    end else if (mul_valid && !stall) begin
      m_busy      <= 1'b1;
      m_cnt       <= 5'(W);
      mul_product <= 33'(mul_a) * 33'(mul_b);
    end else if (m_busy) begin
      if (m_cnt == 0) m_busy <= 1'b0;
      else            m_cnt  <= m_cnt - 5'd1;
    end
  end
  assign mul_ready = (m_busy && m_cnt == 0) || spur;

  // Requester side
  logic [N-1:0]        rv = '0;
  logic [N*W-1:0]      pa = '0, pb = '0;
  logic signed [W-1:0] ea [N];
  logic signed [W-1:0] eb [N];
  assign bus.req_valid = rv;
  assign bus.req_a     = pa;
  assign bus.req_b     = pb;

  int n_vec = 0;
  int n_bad = 0;

  task automatic chk(input string nm, input logic signed [63:0] act, input logic signed [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    end
  endtask

  task automatic load(input int i, input logic signed [W-1:0] a, input logic signed [W-1:0] b);
    pa[6'(i*W) +: W] = a;
    pb[6'(i*W) +: W] = b;
    ea[2'(i)]        = a;
    eb[2'(i)]        = b;
    rv[2'(i)]        = 1'b1;
  endtask

  // One transaction from accept to response handshake; hold>0 keeps resp_ready low that long.
  task automatic run_txn(input string nm, input int exp_id, input longint exp_p, input int hold);
    int w, lat, g;
    logic [63:0] snap;
    #1;
    w = 0;
    while (bus.req_ready == '0 && w < 200) begin
      @(negedge clk);
      w++;
    end
    chk({nm, "_grant"}, bus.req_ready, 64'(4'(1) << exp_id));
    g = -1;
    for (int i = 0; i < N; i++) if (bus.req_ready[2'(i)]) g = i;
    if (g < 0) return;
    @(negedge clk);
    rv[2'(g)] = 1'b0;
    chk({nm, "_mvalid1"}, mul_valid, 1);
    chk({nm, "_mul_a"}, mul_a, ea[2'(g)]);
    chk({nm, "_mul_b"}, mul_b, eb[2'(g)]);
    @(negedge clk);
    chk({nm, "_mvalid0"}, mul_valid, 0);
    lat = 2;
    while (!bus.resp_valid && lat < 80) begin
      @(negedge clk);
      lat++;
    end
    chk({nm, "_latency"}, lat, 19);
    chk({nm, "_id"}, bus.resp_id, exp_id);
    chk({nm, "_product"}, bus.resp_product, exp_p);
    chk({nm, "_error"}, bus.resp_error, 0);
    if (hold > 0) begin
      snap = 64'({bus.resp_valid, bus.resp_id, bus.resp_error, bus.resp_product});
      for (int h = 0; h < hold; h++) begin
        if (h == 3) spur = 1'b1;
        @(negedge clk);
        spur = 1'b0;
        chk({nm, "_stable"}, 64'({bus.resp_valid, bus.resp_id, bus.resp_error, bus.resp_product}), snap);
        chk({nm, "_no_accept"}, {bus.req_ready, mul_valid}, 0);
      end
      bus.resp_ready = 1'b1;
    end
    @(negedge clk);
    chk({nm, "_resp_done"}, bus.resp_valid, 0);
  endtask

  typedef struct {
    int                  ld;
    logic signed [W-1:0] a;
    logic signed [W-1:0] b;
    bit                  run;
    int                  exp_id;
    longint              exp_p;
  } vec_t;

  vec_t tbl [13];

  initial begin
    int w, cnt;
    tbl[0]  = '{0,  16'sd3,      -16'sd5,     1'b1, 0, -15};
    tbl[1]  = '{1,  16'sh8000,   16'sh8000,   1'b1, 1, 1073741824};
    tbl[2]  = '{2,  16'sd32767,  16'sh8000,   1'b1, 2, -1073709056};
    tbl[3]  = '{3,  16'sd0,      16'sd5,      1'b1, 3, 0};
    tbl[4]  = '{0,  16'sd7,      16'sd6,      1'b0, 0, 0};
    tbl[5]  = '{1,  -16'sd100,   16'sd200,    1'b0, 0, 0};
    tbl[6]  = '{2,  16'sd1234,   -16'sd2,     1'b0, 0, 0};
    tbl[7]  = '{3,  -16'sd1,     -16'sd1,     1'b1, 0, 42};
    tbl[8]  = '{0,  16'sd100,    16'sd100,    1'b1, 1, -20000};
    tbl[9]  = '{-1, 16'sd0,      16'sd0,      1'b1, 2, -2468};
    tbl[10] = '{-1, 16'sd0,      16'sd0,      1'b1, 3, 1};
    tbl[11] = '{-1, 16'sd0,      16'sd0,      1'b1, 0, 10000};
    tbl[12] = '{-1, 16'sd0,      16'sd0,      1'b0, 0, 0};

    bus.resp_ready = 1'b1;
    reset = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_mul_reset", mul_reset, 1);
    chk("rst_outputs", 64'({bus.req_ready, bus.resp_valid, bus.resp_id, bus.resp_product,
                            bus.resp_error, mul_valid, mul_a, mul_b}), 0);
    reset = 1'b0;
    @(negedge clk);
    chk("idle_outputs", 64'({bus.req_ready, bus.resp_valid, mul_valid, mul_reset}), 0);

    // Stray mul_ready in IDLE must not move the FSM.
    spur = 1'b1;
    @(negedge clk);
    spur = 1'b0;
    @(negedge clk);
    chk("idle_stray_ready", {bus.resp_valid, mul_valid}, 0);

    for (int v = 0; v < 13; v++) begin
      if (tbl[v].ld >= 0) load(tbl[v].ld, tbl[v].a, tbl[v].b);
      if (tbl[v].run) run_txn($sformatf("v%0d", v), tbl[v].exp_id, tbl[v].exp_p, 0);
    end

    // Backpressure with another requester waiting.
    load(1, 16'sd5, 16'sd5);
    load(2, -16'sd3, 16'sd4);
    bus.resp_ready = 1'b0;
    run_txn("bp", 1, 25, 10);
    chk("bp_next_grant", bus.req_ready, 4'b0100);
    run_txn("bp_after", 2, -12, 0);

    // Reset during BUSY drops the transaction and clears rr_ptr.
    load(3, 16'sd9, 16'sd9);
    #1;
    w = 0;
    while (bus.req_ready == '0 && w < 50) begin
      @(negedge clk);
      w++;
    end
    chk("mid_grant", bus.req_ready, 4'b1000);
    repeat (8) @(negedge clk);
    reset = 1'b1;
    rv = '0;
    #1;
    chk("mid_mul_reset", mul_reset, 1);
    @(negedge clk);
    chk("mid_outputs", 64'({bus.req_ready, bus.resp_valid, bus.resp_id, bus.resp_product,
                            bus.resp_error, mul_valid, mul_a, mul_b}), 0);
    reset = 1'b0;
    cnt = 0;
    for (int c = 0; c < 30; c++) begin
      @(negedge clk);
      if (bus.resp_valid || mul_ready) cnt++;
    end
    chk("mid_no_response", cnt, 0);
    load(3, 16'sd2, 16'sd2);
    load(0, -16'sd7, 16'sd8);
    run_txn("post_rst0", 0, -56, 0);
    run_txn("post_rst3", 3, 4, 0);

`ifdef MUL_ARB_TIMEOUT_EN
    // Multiplier that never answers: abort after 40 BUSY cycles.
    stall = 1'b1;
    load(0, 16'sd1, 16'sd1);
    #1;
    w = 0;
    while (bus.req_ready == '0 && w < 50) begin
      @(negedge clk);
      w++;
    end
    chk("to_grant", bus.req_ready, 4'b0001);
    @(negedge clk);
    rv = '0;
    w = 1;
    while (!bus.resp_valid && w < 100) begin
      @(negedge clk);
      w++;
    end
    chk("to_latency", w, 42);
    chk("to_mul_reset", mul_reset, 1);
    chk("to_error", bus.resp_error, 1);
    chk("to_product", bus.resp_product, 0);
    chk("to_id", bus.resp_id, 0);
    @(negedge clk);
    chk("to_mul_reset_end", mul_reset, 0);
    stall = 1'b0;
    load(0, 16'sd2, 16'sd5);
    load(1, 16'sd3, 16'sd3);
    run_txn("to_next1", 1, 9, 0);
    run_txn("to_next0", 0, 10, 0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish, %0d miscompares so far", n_bad);
    $fatal(1);
  end

endmodule
